key5_debounce: RTL and testbench

- Push-button conditioner: synchronises a raw, bouncing key input, debounces it and emits a single-clock press pulse on `dout`.
- Sits between a board key pin and control logic. Its consumer counts edges of `dout` to step a display-pattern selector in the VGA test-pattern generator.
- One pulse per physical press, regardless of bounce.

---
 rtl/key5_pkg.sv | 27 ++
 rtl/key5_sync2.sv | 32 +++
 rtl/key5_debounce.sv | 115 +++++++++++
 tb/tb_key5_debounce.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key5_pkg.sv
// rtl/key5_pkg.sv - shared constants and helpers for the key5 push-button conditioner
// Purpose : default timing constants, debounced-state encoding and
//           released/pressed key levels derived from the key polarity.
// Ports   : none (package).
// Config  : REPEAT_CYCLES_DEF only matters when KEY5_AUTOREPEAT_EN is defined.
package key5_pkg;

   localparam int unsigned STABLE_CYCLES_DEF = 32'd50000;
   localparam int unsigned CNT_W_DEF         = 16;
   localparam int unsigned REP_W             = 24;
   localparam int unsigned REPEAT_CYCLES_DEF = 32'd5000000;

   typedef enum logic {
      KEY_RELEASED = 1'b0,
      KEY_PRESSED  = 1'b1
   } key_state_e;

   // Pin level of an idle (released) key for the given polarity.
   function automatic logic released_level(input bit active_low);
      return active_low ? 1'b1 : 1'b0;
   endfunction

   function automatic logic pressed_level(input bit active_low);
      return ~released_level(active_low);
   endfunction

endpackage

// File: rtl/key5_sync2.sv
// rtl/key5_sync2.sv - two-flop synchroniser for an asynchronous input pin
// Purpose : brings an asynchronous level into the clk_i domain; the only
//           place metastability is absorbed.
// Ports   : clk_i     - sampling clock
//           rst_i     - asynchronous active-high reset
//           rst_val_i - level both flops take in reset (tie to a constant)
//           d_i       - asynchronous input level
//           q_o       - synchronised level (second flop)
module key5_sync2 (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rst_val_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= rst_val_i;
         sync_q <= rst_val_i;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/key5_debounce.sv
// rtl/key5_debounce.sv - key synchroniser, debouncer and press-pulse generator
// Purpose : synchronises a raw bouncing key, accepts a new level only after
//           STABLE_CYCLES consecutive differing samples, and emits a
//           one-clock pulse on dout for every accepted press.
// Ports   : CLK   - system clock, rising edge
//           RESET - asynchronous active-high reset
//           din   - raw key level, asynchronous, may bounce
//           dout  - one-CLK pulse per debounced press
// Config  : define KEY5_AUTOREPEAT_EN to add auto-repeat pulses every
//           REPEAT_CYCLES clocks while the key stays pressed.
module key5_debounce
   import key5_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = STABLE_CYCLES_DEF,
   parameter int unsigned CNT_W          = CNT_W_DEF,
   parameter bit          KEY_ACTIVE_LOW = 1'b1
`ifdef KEY5_AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_CYCLES  = REPEAT_CYCLES_DEF
`endif
) (
   input  logic CLK,
   input  logic RESET,
   input  logic din,
   output logic dout
);

   localparam logic REL_LVL = released_level(KEY_ACTIVE_LOW);
   localparam logic PRS_LVL = pressed_level(KEY_ACTIVE_LOW);

   logic             sync;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             press_evt;
   logic             sync_pressed;
   logic             sync_differs;
   logic             cnt_done;

   key5_sync2 u_sync (
      .clk_i     (CLK),
      .rst_i     (RESET),
      .rst_val_i (REL_LVL),
      .d_i       (din),
      .q_o       (sync)
   );

   assign sync_pressed = (sync == PRS_LVL);
   assign sync_differs = (sync_pressed != (state_q == KEY_PRESSED));
   assign cnt_done     = (cnt_q == CNT_W'(STABLE_CYCLES - 1));

   // Any sample equal to the accepted state restarts the count, so a level
   // is accepted only after STABLE_CYCLES consecutive differing samples.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_evt = 1'b0;
      if (!sync_differs) begin
         cnt_d = '0;
      end else if (cnt_done) begin
         cnt_d     = '0;
         state_d   = sync_pressed ? KEY_PRESSED : KEY_RELEASED;
         press_evt = sync_pressed;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

`ifdef KEY5_AUTOREPEAT_EN
   logic [REP_W-1:0] rep_q, rep_d;
   logic             rep_fire;

   // Runs only across edges where the key stays pressed; the initial press
   // edge and any release clear it, so the first repeat lands REPEAT_CYCLES
   // after the press pulse.
   always_comb begin
      rep_d    = '0;
      rep_fire = 1'b0;
      if (state_q == KEY_PRESSED && state_d == KEY_PRESSED) begin
         if (rep_q == REP_W'(REPEAT_CYCLES - 1)) begin
            rep_fire = 1'b1;
         end else begin
            rep_d = rep_q + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

   assign dout_d = press_evt | rep_fire;
`else
   assign dout_d = press_evt;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= KEY_RELEASED;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: tb/tb_key5_debounce.sv
// tb/tb_key5_debounce.sv - self-checking bench for key5_debounce
module tb_key5_debounce;

   localparam int S = 16;
   localparam int R = 32;
`ifdef KEY5_AUTOREPEAT_EN
   localparam int P_LONG  = 2;   // 50-cycle press: pulses at 18 and 50
   localparam int P_HOLD  = 6;   // 200-cycle hold: 18,50,82,114,146,178
`else
   localparam int P_LONG  = 1;
   localparam int P_HOLD  = 1;
`endif

   logic CLK = 1'b0;
   logic RESET;
   logic din;
   logic dout;

   always #5 CLK = ~CLK;

   key5_debounce #(
      .STABLE_CYCLES  (S),
      .CNT_W          (16),
      .KEY_ACTIVE_LOW (1'b1)
`ifdef KEY5_AUTOREPEAT_EN
      ,
      .REPEAT_CYCLES  (R)
`endif
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .din   (din),
      .dout  (dout)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the key level (0 = pressed) is accepted once the last
   // S synchronised samples all agree and differ from the accepted level.
   bit m_ff1, m_sync, m_acc, m_exp;
   bit win[$];
   int m_rep;

   function automatic void model_reset();
      m_ff1  = 1'b1;
      m_sync = 1'b1;
      m_acc  = 1'b1;
      m_exp  = 1'b0;
      m_rep  = 0;
      win.delete();
   endfunction

   function automatic void model_edge();
      bit s, prev, all;
      s     = m_sync;
      prev  = m_acc;
      m_exp = 1'b0;
      win.push_back(s);
      if (win.size() > S) void'(win.pop_front());
      if (win.size() == S && s != m_acc) begin
         all = 1'b1;
         foreach (win[i]) if (win[i] != s) all = 1'b0;
         if (all) begin
            m_acc = s;
            if (s == 1'b0) m_exp = 1'b1;
         end
      end
`ifdef KEY5_AUTOREPEAT_EN
      if (prev == 1'b0 && m_acc == 1'b0) begin
         m_rep++;
         if (m_rep == R) begin
            m_exp = 1'b1;
            m_rep = 0;
         end
      end else begin
         m_rep = 0;
      end
`else
      if (prev != m_acc) m_rep = 0;
`endif
      m_sync = m_ff1;
      m_ff1  = din;
   endfunction

   task automatic tick();
      @(posedge CLK);
      if (RESET) model_reset();
      else model_edge();
      #1;
      check("dout_vs_model", dout, m_exp);
   endtask

   typedef struct {
      logic lvl;
      int   cycles;
      int   exp_pulses;
      int   exp_first;
   } vec_t;

   vec_t tbl[$];

   // Returns the edge index (1-based) of the first pulse within limit, or -1.
   task automatic wait_pulse(input int limit, output int first);
      first = -1;
      for (int k = 1; k <= limit; k++) begin
         tick();
         if (dout === 1'b1 && first < 0) first = k;
         if (first >= 0) break;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses, first, len;

      // Reset state
      RESET = 1'b1;
      din   = 1'b1;
      model_reset();
      #1;
      check("reset_dout", dout, 0);
      check("reset_cnt", dut.cnt_q, 0);
      repeat (3) tick();
      RESET = 1'b0;

      tbl.push_back('{lvl:1'b1, cycles:100, exp_pulses:0,      exp_first:-1});
      tbl.push_back('{lvl:1'b0, cycles:50,  exp_pulses:P_LONG, exp_first:18});
      tbl.push_back('{lvl:1'b1, cycles:40,  exp_pulses:0,      exp_first:-1});
      for (int i = 0; i < 6; i++) begin
         tbl.push_back('{lvl:1'b0, cycles:5, exp_pulses:0, exp_first:-1});
         tbl.push_back('{lvl:1'b1, cycles:5, exp_pulses:0, exp_first:-1});
      end
      tbl.push_back('{lvl:1'b0, cycles:30, exp_pulses:1, exp_first:18});
      tbl.push_back('{lvl:1'b1, cycles:40, exp_pulses:0, exp_first:-1});
      tbl.push_back('{lvl:1'b0, cycles:15, exp_pulses:0, exp_first:-1});
      tbl.push_back('{lvl:1'b1, cycles:30, exp_pulses:0, exp_first:-1});
      tbl.push_back('{lvl:1'b0, cycles:16, exp_pulses:0, exp_first:-1});
      tbl.push_back('{lvl:1'b1, cycles:40, exp_pulses:1, exp_first:2});
      tbl.push_back('{lvl:1'b0, cycles:30, exp_pulses:1, exp_first:18});
      tbl.push_back('{lvl:1'b1, cycles:40, exp_pulses:0, exp_first:-1});
      tbl.push_back('{lvl:1'b0, cycles:30, exp_pulses:1, exp_first:18});
      tbl.push_back('{lvl:1'b1, cycles:40, exp_pulses:0, exp_first:-1});

      foreach (tbl[r]) begin
         din    = tbl[r].lvl;
         pulses = 0;
         first  = -1;
         for (int k = 1; k <= tbl[r].cycles; k++) begin
            tick();
            if (dout === 1'b1) begin
               pulses++;
               if (first < 0) first = k;
            end
         end
         check($sformatf("row%0d_pulses", r), pulses, tbl[r].exp_pulses);
         check($sformatf("row%0d_first", r), first, tbl[r].exp_first);
      end

      // Glitch one sample short of acceptance: counter climbs then clears.
      din = 1'b0;
      repeat (15) tick();
      check("glitch_cnt_peak", dut.cnt_q, 13);
      din = 1'b1;
      repeat (5) tick();
      check("glitch_cnt_clear", dut.cnt_q, 0);
      repeat (20) tick();

      // Asynchronous reset in the middle of a press count.
      din = 1'b0;
      repeat (12) tick();
      check("midcount_cnt", dut.cnt_q, 10);
      #2;
      RESET = 1'b1;
      model_reset();
      #1;
      check("midcount_rst_dout", dout, 0);
      check("midcount_rst_cnt", dut.cnt_q, 0);
      repeat (2) tick();
      RESET = 1'b0;
      pulses = 0;
      first  = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (dout === 1'b1) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
      check("held_after_rst_first", first, 18);
      check("held_200_pulses", pulses, P_HOLD);
      din = 1'b1;
      repeat (60) tick();

      // Asynchronous reset while dout is high, key still held.
      din = 1'b0;
      wait_pulse(40, first);
      check("prepulse_first", first, 18);
      #2;
      RESET = 1'b1;
      model_reset();
      #1;
      check("midpulse_rst_dout", dout, 0);
      repeat (2) tick();
      RESET = 1'b0;
      wait_pulse(40, first);
      check("repress_after_rst_first", first, 18);
      din = 1'b1;
      repeat (60) tick();

      // Randomised runs checked edge by edge against the model.
      for (int n = 0; n < 250; n++) begin
         din = ~din;
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(S - 2, S + 40)
                                            : $urandom_range(1, S + 2);
         repeat (len) tick();
         if ($urandom_range(0, 40) == 0) begin
            RESET = 1'b1;
            model_reset();
            repeat ($urandom_range(1, 3)) tick();
            RESET = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
